// File: rtl/draw_pkg.sv
// Shared drawing definitions: screen size, colour encoding, start/done state enum.
// Latency: n/a (declarations only).
// Backpressure: n/a; the start/done handshake is level-based and owned by each drawer.
package draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] GREEN = 3'b010;

    // Common sequencing for fillscreen, circle and reuleaux drawers.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        PLOT = 2'd2,
        DONE = 2'd3
    } draw_state_t;

endpackage

// File: rtl/circle_octant_point.sv
// Maps a Bresenham offset pair onto one of eight symmetric octant points and flags on-screen points.
// Latency: combinational.
// Backpressure: none; the caller decides whether the point is consumed.
import draw_pkg::*;

module circle_octant_point #(
    parameter int SCREEN_W = draw_pkg::SCREEN_W,
    parameter int SCREEN_H = draw_pkg::SCREEN_H
) (
    input  logic [7:0]        cx,
    input  logic [6:0]        cy,
    input  logic signed [9:0] ox,
    input  logic signed [9:0] oy,
    input  logic [2:0]        oct,
    output logic signed [9:0] x,
    output logic signed [9:0] y,
    output logic              in_bounds
);

    localparam logic signed [9:0] X_LIMIT = 10'(SCREEN_W);
    localparam logic signed [9:0] Y_LIMIT = 10'(SCREEN_H);

    logic signed [9:0] sx;
    logic signed [9:0] sy;

    assign sx = signed'({2'b00, cx});
    assign sy = signed'({3'b000, cy});

    // Octant selection, then clip against the visible window using signed compares.
    always_comb begin
        x = sx + ox;
        y = sy + oy;
        case (oct)
            3'd0: begin x = sx + ox; y = sy + oy; end
            3'd1: begin x = sx + oy; y = sy + ox; end
            3'd2: begin x = sx - oy; y = sy + ox; end
            3'd3: begin x = sx - ox; y = sy + oy; end
            3'd4: begin x = sx - ox; y = sy - oy; end
            3'd5: begin x = sx - oy; y = sy - ox; end
            3'd6: begin x = sx + oy; y = sy - ox; end
            default: begin x = sx + ox; y = sy - oy; end
        endcase
        in_bounds = (x >= 10'sd0) && (x < X_LIMIT) && (y >= 10'sd0) && (y < Y_LIMIT);
    end

endmodule

// File: rtl/circle.sv
// Midpoint circle rasteriser: one octant point per clock on the vga_* bus, level start / held done.
// Latency: start seen at edge k -> first pixel after edge k+2; 8 cycles per iteration; done on the edge after the last pixel.
// Backpressure: none downstream; dropping start mid-draw aborts, done holds until start falls.
import draw_pkg::*;

module circle #(
    parameter int SCREEN_W = draw_pkg::SCREEN_W,
    parameter int SCREEN_H = draw_pkg::SCREEN_H
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [COLOUR_W-1:0] colour,
    input  logic [7:0]          centre_x,
    input  logic [6:0]          centre_y,
    input  logic [7:0]          radius,
    input  logic                start,
    output logic                done,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    draw_state_t         state;
    logic [7:0]          cx_q;
    logic [6:0]          cy_q;
    logic [COLOUR_W-1:0] col_q;
    logic signed [9:0]   ox;
    logic signed [9:0]   oy;
    logic signed [11:0]  crit;
    logic [2:0]          oct;

    logic signed [9:0]   pt_x;
    logic signed [9:0]   pt_y;
    logic                pt_in;

    logic signed [9:0]   ox_n;
    logic signed [9:0]   oy_n;
    logic signed [11:0]  crit_n;
    logic signed [11:0]  ox_w;
    logic signed [11:0]  oy_w;

    // High coordinate bits only feed the bounds check inside the point mapper.
    logic coord_unused;
    assign coord_unused = ^{pt_x[9:8], pt_y[9:7]};

    circle_octant_point #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_point (
        .cx        (cx_q),
        .cy        (cy_q),
        .ox        (ox),
        .oy        (oy),
        .oct       (oct),
        .x         (pt_x),
        .y         (pt_y),
        .in_bounds (pt_in)
    );

    // Next Bresenham step; both crit branches use the already-advanced offsets.
    always_comb begin
        oy_n = oy + 10'sd1;
        ox_n = ox;
        if (crit > 12'sd0) begin
            ox_n = ox - 10'sd1;
        end
        ox_w = {{2{ox_n[9]}}, ox_n};
        oy_w = {{2{oy_n[9]}}, oy_n};
        if (crit <= 12'sd0) begin
            crit_n = crit + (oy_w <<< 1) + 12'sd1;
        end else begin
            crit_n = crit + ((oy_w - ox_w) <<< 1) + 12'sd1;
        end
    end

    // Draw sequencer with registered pixel bus; every octant slot costs one cycle even when clipped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            done       <= 1'b0;
            vga_plot   <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= BLACK;
            cx_q       <= 8'd0;
            cy_q       <= 7'd0;
            col_q      <= BLACK;
            ox         <= 10'sd0;
            oy         <= 10'sd0;
            crit       <= 12'sd0;
            oct        <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    vga_plot <= 1'b0;
                    if (start) begin
                        cx_q  <= centre_x;
                        cy_q  <= centre_y;
                        col_q <= colour;
                        ox    <= signed'({2'b00, radius});
                        oy    <= 10'sd0;
                        crit  <= 12'sd1 - signed'({4'b0000, radius});
                        state <= INIT;
                    end
                end
                INIT: begin
                    vga_plot <= 1'b0;
                    oct      <= 3'd0;
                    state    <= start ? PLOT : IDLE;
                end
                PLOT: begin
                    if (!start) begin
                        vga_plot <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        vga_x      <= pt_x[7:0];
                        vga_y      <= pt_y[6:0];
                        vga_colour <= col_q;
                        vga_plot   <= pt_in;
                        oct        <= oct + 3'd1;
                        if (oct == 3'd7) begin
                            ox   <= ox_n;
                            oy   <= oy_n;
                            crit <= crit_n;
                            if (oy_n > ox_n) begin
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    vga_plot <= 1'b0;
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_circle.sv
// Bench for circle: vector table of circles plus abort and mid-draw reset sequences.
// Expected pixel streams come from an integer reference of the midpoint algorithm, queued per draw.
// Outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
import draw_pkg::*;

module tb_circle;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [COLOUR_W-1:0] colour = '0;
    logic [7:0]          centre_x = '0;
    logic [6:0]          centre_y = '0;
    logic [7:0]          radius = '0;
    logic                start = 1'b0;
    logic                done;
    logic [7:0]          vga_x;
    logic [6:0]          vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;

    always #5 clk = ~clk;

    circle dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .colour     (colour),
        .centre_x   (centre_x),
        .centre_y   (centre_y),
        .radius     (radius),
        .start      (start),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    typedef struct {
        logic [7:0]          r;
        logic [7:0]          cx;
        logic [6:0]          cy;
        logic [COLOUR_W-1:0] col;
        int                  exp_cycles;
    } vec_t;

    typedef struct {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
    } pix_t;

    int   checks = 0;
    int   errors = 0;
    pix_t exp_q[$];
    pix_t obs[$];
    int   last_cycles;
    vec_t vecs[5];
    int   cyc[5];
    int   r1_x[8] = '{6, 5, 5, 4, 4, 5, 5, 6};
    int   r1_y[8] = '{5, 6, 6, 5, 5, 4, 4, 5};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Integer reference of the midpoint circle: one queue entry per octant slot.
    task automatic model_push(input int r, input int cx, input int cy);
        int   ox, oy, crit, x, y;
        pix_t p;
        ox = r;
        oy = 0;
        crit = 1 - r;
        do begin
            for (int o = 0; o < 8; o++) begin
                case (o)
                    0: begin x = cx + ox; y = cy + oy; end
                    1: begin x = cx + oy; y = cy + ox; end
                    2: begin x = cx - oy; y = cy + ox; end
                    3: begin x = cx - ox; y = cy + oy; end
                    4: begin x = cx - ox; y = cy - oy; end
                    5: begin x = cx - oy; y = cy - ox; end
                    6: begin x = cx + oy; y = cy - ox; end
                    default: begin x = cx + ox; y = cy - oy; end
                endcase
                p.plot = (x >= 0) && (x < SCREEN_W) && (y >= 0) && (y < SCREEN_H);
                p.x = x[7:0];
                p.y = y[6:0];
                exp_q.push_back(p);
            end
            oy++;
            if (crit <= 0) begin
                crit += 2 * oy + 1;
            end else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end while (oy <= ox);
    endtask

    // Full draw: start, two quiet cycles, scoreboarded pixel stream, done handshake.
    task automatic run_draw(input vec_t v, input int hold_done);
        pix_t e, a;
        radius   = v.r;
        centre_x = v.cx;
        centre_y = v.cy;
        colour   = v.col;
        start    = 1'b1;
        exp_q.delete();
        obs.delete();
        last_cycles = 0;
        model_push(int'(v.r), int'(v.cx), int'(v.cy));
        @(posedge clk); #1;
        chk("init_quiet", {done, vga_plot}, 0);
        @(posedge clk); #1;
        chk("pre_pixel_quiet", {done, vga_plot}, 0);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            a.plot = vga_plot;
            a.x = vga_x;
            a.y = vga_y;
            obs.push_back(a);
            last_cycles++;
            if (e.plot) begin
                checks++;
                if ({vga_plot, vga_x, vga_y, vga_colour, done} != {1'b1, e.x, e.y, v.col, 1'b0}) begin
                    errors++;
                    $display("FAIL pixel[%0d] r=%0d: got plot=%0d (%0d,%0d) col=%0d done=%0d, expected plot=1 (%0d,%0d) col=%0d done=0",
                             last_cycles - 1, v.r, vga_plot, vga_x, vga_y, vga_colour, done, e.x, e.y, v.col);
                end
            end else begin
                chk("clipped_slot", {done, vga_plot}, 0);
            end
        end
        @(posedge clk); #1;
        chk("done_rise", {done, vga_plot}, 2);
        repeat (hold_done) begin
            @(posedge clk); #1;
            chk("done_hold", {done, vga_plot}, 2);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("done_fall", {done, vga_plot}, 0);
    endtask

    initial begin
        int   bad, cnt, dx, dy, d;
        vec_t v;

        vecs[0] = '{8'd40, 8'd80, 7'd60, GREEN,  0};
        vecs[1] = '{8'd0,  8'd10, 7'd10, 3'b101, 8};
        vecs[2] = '{8'd1,  8'd5,  7'd5,  3'b111, 16};
        vecs[3] = '{8'd10, 8'd0,  7'd0,  3'b011, 0};
        vecs[4] = '{8'd10, 8'd80, 7'd60, 3'b001, 0};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {done, vga_plot, vga_x, vga_y, vga_colour}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_quiet", {done, vga_plot}, 0);

        for (int i = 0; i < 5; i++) begin
            run_draw(vecs[i], (i == 0) ? 2 : 0);
            cyc[i] = last_cycles;
            if (vecs[i].exp_cycles != 0) begin
                chk("pixel_cycle_count", last_cycles, vecs[i].exp_cycles);
            end
            case (i)
                0: begin
                    chk("r40_first_x", int'(obs[0].x), 120);
                    chk("r40_first_y", int'(obs[0].y), 60);
                    chk("r40_second_x", int'(obs[1].x), 80);
                    chk("r40_second_y", int'(obs[1].y), 100);
                    chk("r40_multiple_of_8", last_cycles % 8, 0);
                    bad = 0;
                    foreach (obs[k]) begin
                        if (obs[k].plot) begin
                            dx = int'(obs[k].x) - 80;
                            dy = int'(obs[k].y) - 60;
                            d = dx * dx + dy * dy - 1600;
                            if (d > 40 || d < -40 || obs[k].x >= 8'd160 || obs[k].y >= 7'd120) bad++;
                        end
                    end
                    chk("r40_on_circle", bad, 0);
                end
                1: begin
                    cnt = 0;
                    foreach (obs[k]) begin
                        if (obs[k].plot && obs[k].x == 8'd10 && obs[k].y == 7'd10) cnt++;
                    end
                    chk("r0_all_at_centre", cnt, 8);
                end
                2: begin
                    for (int k = 0; k < 8; k++) begin
                        chk("r1_pass1_x", int'(obs[k].x), r1_x[k]);
                        chk("r1_pass1_y", int'(obs[k].y), r1_y[k]);
                    end
                end
                3: begin
                    chk("clip_oct0", {obs[0].plot, obs[0].x, obs[0].y}, {1'b1, 8'd10, 7'd0});
                    chk("clip_oct1", {obs[1].plot, obs[1].x, obs[1].y}, {1'b1, 8'd0, 7'd10});
                    chk("clip_oct3_hidden", int'(obs[3].plot), 0);
                end
                default: begin
                end
            endcase
        end
        chk("clip_same_latency", cyc[3], cyc[4]);

        // Abort after five pixel cycles, then redraw from octant 0
        v = '{8'd20, 8'd80, 7'd60, 3'b110, 0};
        radius = v.r;
        centre_x = v.cx;
        centre_y = v.cy;
        colour = v.col;
        start = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("abort_5th_pixel_live", int'(vga_plot), 1);
        start = 1'b0;
        @(posedge clk); #1;
        chk("abort_plot_drop", {done, vga_plot}, 0);
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || vga_plot) bad++;
        end
        chk("abort_stays_quiet", bad, 0);
        run_draw(v, 0);

        // Reset mid-draw with start held, then a fresh draw
        v = '{8'd30, 8'd70, 7'd50, 3'b100, 0};
        radius = v.r;
        centre_x = v.cx;
        centre_y = v.cy;
        colour = v.col;
        start = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midreset_outputs", {done, vga_plot, vga_x, vga_y, vga_colour}, 0);
        rst_n = 1'b1;
        run_draw(v, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
